// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// stage-indexed stall and synchronous flush. Define PIPE_STAGE_STATS_EN for transfer/bubble counters.
module pipe_stage_buf #(
  parameter int                DATA_W    = 80,
  parameter int                STALL_W   = 6,
  parameter int                STAGE_IDX = 4,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_sign,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
`ifdef PIPE_STAGE_STATS_EN
  output logic [31:0]        stat_xfer,
  output logic [31:0]        stat_bubble,
`endif
  input  logic               out_ready
);

  // bit0 = main entry valid, bit1 = skid entry valid; 2'b10 is unreachable
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_t;

  localparam logic [STALL_W-1:0] STALL_MASK = STALL_W'(1) << STAGE_IDX;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_main_d;
  logic [DATA_W-1:0]   r_skid_d;

  logic                w_stall_here;
  logic                w_main_v;
  logic                w_skid_v;
  logic                w_in_fire;
  logic                w_out_fire;
  logic                w_main_ld;
  logic                w_main_from_skid;
  logic                w_skid_ld;

  assign w_stall_here = |(stall_sign & STALL_MASK);
  assign w_main_v     = r_state[0];
  assign w_skid_v     = r_state[1];
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_in_fire) w_state_nxt = S_ONE;
        S_ONE: begin
          if (w_in_fire && !w_out_fire)      w_state_nxt = S_FULL;
          else if (!w_in_fire && w_out_fire) w_state_nxt = S_EMPTY;
        end
        S_FULL:  if (w_out_fire) w_state_nxt = S_ONE;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Output decode; out_valid is also gated by rst so a bubble shows throughout reset
  always_comb begin
    in_ready         = !w_skid_v && !w_stall_here && rst;
    out_valid        = w_main_v && !w_stall_here && rst;
    out_data         = out_valid ? r_main_d : NOP_VALUE;
    w_main_ld        = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_ld        = 1'b0;
    case (r_state)
      S_EMPTY: w_main_ld = w_in_fire;
      S_ONE: begin
        w_main_ld = w_in_fire && w_out_fire;
        w_skid_ld = w_in_fire && !w_out_fire;
      end
      S_FULL: begin
        w_main_ld        = w_out_fire;
        w_main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_main_d <= NOP_VALUE;
      r_skid_d <= NOP_VALUE;
    end else begin
      if (w_main_ld) r_main_d <= w_main_from_skid ? r_skid_d : in_data;
      if (w_skid_ld) r_skid_d <= in_data;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stat_xfer;
  logic [31:0] r_stat_bubble;

  // A beat delivered in the flush cycle still counts; flush never clears counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_xfer   <= '0;
      r_stat_bubble <= '0;
    end else begin
      if (w_out_fire)               r_stat_xfer   <= r_stat_xfer + 32'd1;
      if (w_main_v && w_stall_here) r_stat_bubble <= r_stat_bubble + 32'd1;
    end
  end

  assign stat_xfer   = r_stat_xfer;
  assign stat_bubble = r_stat_bubble;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: reset, streaming, backpressure, stall, flush, mid-stream reset.
// Define PIPE_STAGE_STATS_EN to also check the statistics counters.
module tb_pipe_stage_buf;
  localparam int               DW  = 80;
  localparam int               SW  = 6;
  localparam logic [DW-1:0]    NOP = 80'h0000_0000_0000_0BAD_F00D;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] stall_sign;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]   stat_xfer;
  logic [31:0]   stat_bubble;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(
    .DATA_W(DW), .STALL_W(SW), .STAGE_IDX(4), .NOP_VALUE(NOP)
  ) dut (
    .clk(clk), .rst(rst), .stall_sign(stall_sign), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
`ifdef PIPE_STAGE_STATS_EN
    .stat_xfer(stat_xfer), .stat_bubble(stat_bubble),
`endif
    .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; stall_sign = '0; flush = 1'b0;
    in_valid = 1'b1; in_data = 80'h55; out_ready = 1'b0;

    // Reset held two cycles with upstream offering 0x55
    tick(); #1;
    chk("rst_c1_out_valid", out_valid, 0);
    chk("rst_c1_out_data", out_data, NOP);
    chk("rst_c1_in_ready", in_ready, 0);
    tick(); #1;
    chk("rst_c2_out_valid", out_valid, 0);
    chk("rst_c2_out_data", out_data, NOP);
    chk("rst_c2_in_ready", in_ready, 0);
    rst = 1'b1; in_valid = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // Streaming 0x01..0x08
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i); #1;
      chk("stream_in_ready", in_ready, 1);
      if (i > 1) begin
        chk("stream_out_valid", out_valid, 1);
        chk("stream_out_data", out_data, DW'(i - 1));
      end
      tick();
    end
    in_valid = 1'b0; #1;
    chk("stream_last_valid", out_valid, 1);
    chk("stream_last_data", out_data, 80'h08);
    tick(); #1;
    chk("stream_drained", out_valid, 0);
    chk("stream_drained_data", out_data, NOP);

    // Backpressure: A1 in main, A2 in skid, A3 held upstream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 80'hA1; #1;
    chk("bp_a1_ready", in_ready, 1);
    tick();
    in_data = 80'hA2; #1;
    chk("bp_a2_ready", in_ready, 1);
    chk("bp_a2_out", out_data, 80'hA1);
    tick();
    in_data = 80'hA3; #1;
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_out", out_data, 80'hA1);
    tick(); #1;
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_out", out_data, 80'hA1);
    out_ready = 1'b1; #1;
    chk("bp_rel_a1", out_data, 80'hA1);
    tick();
    chk("bp_rel_a2", out_data, 80'hA2);
    chk("bp_rel_a2_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; #1;
    chk("bp_rel_a3", out_data, 80'hA3);
    chk("bp_rel_a3_valid", out_valid, 1);
    tick();
    chk("bp_empty", out_valid, 0);

    // Stall bubble on main=0x10
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 80'h10; #1;
    tick();
    in_valid = 1'b0; #1;
    chk("stall_pre_data", out_data, 80'h10);
    stall_sign = 6'b001000; #1;
    chk("other_bit_no_stall", out_valid, 1);
    stall_sign = 6'b010000; in_valid = 1'b1; in_data = 80'h99; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_out_valid", out_valid, 0);
      chk("stall_out_data", out_data, NOP);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    stall_sign = '0; in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("stall_rel_valid", out_valid, 1);
    chk("stall_rel_data", out_data, 80'h10);
`ifdef PIPE_STAGE_STATS_EN
    chk("stat_bubble", stat_bubble, 3);
`endif
    out_ready = 1'b1;
    tick(); #1;
    chk("stall_drained", out_valid, 0);
`ifdef PIPE_STAGE_STATS_EN
    chk("stat_xfer_12", stat_xfer, 12);
`endif

    // Flush while FULL with B3 offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 80'hB1; tick();
    in_data = 80'hB2; tick();
    in_data = 80'hB3; flush = 1'b1; #1;
    chk("flush_full_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, NOP);
    chk("flush_in_ready", in_ready, 1);
    // Flush in ONE discards a beat accepted the same cycle
    in_valid = 1'b1; in_data = 80'hC1; tick();
    in_data = 80'hC2; flush = 1'b1; #1;
    chk("flush_one_ready", in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("flush_one_valid", out_valid, 0);
    tick(); #1;
    chk("flush_no_ghost", out_valid, 0);
    chk("flush_no_ghost_data", out_data, NOP);

    // Reset mid-stream while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 80'hD1; tick();
    in_data = 80'hD2; tick();
    chk("pre_rst_full_ready", in_ready, 0);
    rst = 1'b0; tick(); #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, NOP);
    chk("mid_rst_in_ready", in_ready, 0);
`ifdef PIPE_STAGE_STATS_EN
    chk("mid_rst_stat_xfer", stat_xfer, 0);
    chk("mid_rst_stat_bubble", stat_bubble, 0);
`endif
    rst = 1'b1; in_valid = 1'b0; #1;
    chk("after_rst_out_valid", out_valid, 0);
    chk("after_rst_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 80'hE1; out_ready = 1'b1; tick();
    in_valid = 1'b0; #1;
    chk("after_rst_e1", out_data, 80'hE1);
    tick(); #1;
    chk("after_rst_empty", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
